// File: rtl/stepper_step_gen_if.sv
// Register bus between a host and stepper_step_gen.
//   avs_address   word address: channel = address[AW-1:2], register = address[1:0]
//   avs_write     single-cycle write strobe (no waitrequest)
//   avs_writedata write data
//   avs_read      read strobe
//   avs_readdata  registered read data, valid one clock after avs_read
// Modports: master drives the strobes, slave drives avs_readdata.
interface stepper_step_gen_if #(
  parameter int AW = 3
);
  logic [AW-1:0] avs_address;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic          avs_read;
  logic [31:0]   avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/stepper_step_gen.sv
// Multi-channel STEP/DIR pulse generator for EasyDriver-style stepper drivers.
// Each channel has its own register set and move FSM; channels share only the bus.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   bus       register bus (slave side)
//   step      STEP pulse per channel
//   dir       direction per channel (latched direction while moving)
//   enable_n  active-low driver enable per channel (~CTRL.en)
//   irq       registered OR over channels of (done & irq_en)
//
// state   | meaning
// S_IDLE  | no move in progress, step low
// S_SETUP | DIR settling before the first STEP edge, step low
// S_HIGH  | STEP high for one half-period
// S_LOW   | STEP low for one half-period; step count decremented at its end
module stepper_step_gen #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 24,
  parameter int DIV_W     = 20,
  parameter int SETUP_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  stepper_step_gen_if.slave   bus,
  output logic [N_CH-1:0]     step,
  output logic [N_CH-1:0]     dir,
  output logic [N_CH-1:0]     enable_n,
  output logic                irq
);

  // Timer must hold both the setup delay and a half-period reload value.
  localparam int SW    = $clog2(SETUP_CYC + 1);
  localparam int TMR_W = (DIV_W > SW) ? DIV_W : SW;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t              state_q      [N_CH];
  state_t              state_d      [N_CH];
  logic [TMR_W-1:0]    tmr_q        [N_CH];
  logic [TMR_W-1:0]    tmr_d        [N_CH];
  logic [CNT_W-1:0]    steps_sh_q   [N_CH];
  logic [CNT_W-1:0]    steps_sh_d   [N_CH];
  logic [CNT_W-1:0]    remaining_q  [N_CH];
  logic [CNT_W-1:0]    remaining_d  [N_CH];
  logic [DIV_W-1:0]    period_sh_q  [N_CH];
  logic [DIV_W-1:0]    period_sh_d  [N_CH];
  logic [DIV_W-1:0]    period_act_q [N_CH];
  logic [DIV_W-1:0]    period_act_d [N_CH];
  logic [TMR_W-1:0]    reload       [N_CH];

  logic [N_CH-1:0] en_q, en_d, dir_q, dir_d, irq_en_q, irq_en_d;
  logic [N_CH-1:0] dir_act_q, dir_act_d, done_q, done_d;
  logic [N_CH-1:0] wr_ctrl, wr_steps, wr_period;
  logic [N_CH-1:0] abort_w, start_w, done_set, done_clr;
  logic            irq_q, irq_d;
  logic [31:0]     readdata_q, readdata_d, rd_data;
  int              ch_sel;
  logic [1:0]      reg_sel;

  // Bus decode; an address whose channel field is >= N_CH matches no channel.
  always_comb begin
    ch_sel  = int'(bus.avs_address >> 2);
    reg_sel = bus.avs_address[1:0];
    for (int i = 0; i < N_CH; i++) begin
      wr_ctrl[i]   = bus.avs_write && (ch_sel == i) && (reg_sel == 2'd0);
      wr_steps[i]  = bus.avs_write && (ch_sel == i) && (reg_sel == 2'd1);
      wr_period[i] = bus.avs_write && (ch_sel == i) && (reg_sel == 2'd2);
      // Clearing en on a running channel behaves exactly like abort.
      abort_w[i]   = wr_ctrl[i] && (bus.avs_writedata[4] ||
                                    (en_q[i] && !bus.avs_writedata[0]));
      start_w[i]   = wr_ctrl[i] && bus.avs_writedata[3] && bus.avs_writedata[0] &&
                     !abort_w[i] && (state_q[i] == S_IDLE);
      done_clr[i]  = wr_ctrl[i] && bus.avs_writedata[5];
      // A half-period of 0 runs as 1, so the reload is P-1 floored at 0.
      reload[i]    = (period_act_q[i] == '0) ? '0 :
                     TMR_W'(period_act_q[i] - DIV_W'(1));
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    steps_sh_d   = steps_sh_q;
    remaining_d  = remaining_q;
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    en_d         = en_q;
    dir_d        = dir_q;
    irq_en_d     = irq_en_q;
    dir_act_d    = dir_act_q;
    done_set     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_ctrl[i]) begin
        en_d[i]     = bus.avs_writedata[0];
        dir_d[i]    = bus.avs_writedata[1];
        irq_en_d[i] = bus.avs_writedata[2];
      end
      // Shadow registers only; a running move keeps its latched copies.
      if (wr_steps[i])  steps_sh_d[i]  = bus.avs_writedata[CNT_W-1:0];
      if (wr_period[i]) period_sh_d[i] = bus.avs_writedata[DIV_W-1:0];

      if (abort_w[i]) begin
        state_d[i] = S_IDLE;
        tmr_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            if (start_w[i]) begin
              if (steps_sh_q[i] == '0) begin
                done_set[i] = 1'b1;
              end else begin
                remaining_d[i]  = steps_sh_q[i];
                period_act_d[i] = period_sh_q[i];
                dir_act_d[i]    = bus.avs_writedata[1];
                tmr_d[i]        = TMR_W'(SETUP_CYC - 1);
                state_d[i]      = S_SETUP;
              end
            end
          end
          S_SETUP: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = S_HIGH;
              tmr_d[i]   = reload[i];
            end else begin
              tmr_d[i] = tmr_q[i] - TMR_W'(1);
            end
          end
          S_HIGH: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = S_LOW;
              tmr_d[i]   = reload[i];
            end else begin
              tmr_d[i] = tmr_q[i] - TMR_W'(1);
            end
          end
          S_LOW: begin
            if (tmr_q[i] == '0) begin
              remaining_d[i] = remaining_q[i] - CNT_W'(1);
              if (remaining_q[i] == CNT_W'(1)) begin
                state_d[i]  = S_IDLE;
                done_set[i] = 1'b1;
              end else begin
                state_d[i] = S_HIGH;
                tmr_d[i]   = reload[i];
              end
            end else begin
              tmr_d[i] = tmr_q[i] - TMR_W'(1);
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Set beats clear when both happen in one cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      done_d[i] = done_set[i] ? 1'b1 : (done_clr[i] ? 1'b0 : done_q[i]);
    end
  end

  // irq is computed from next-state values so it tracks done without extra lag.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      irq_d = irq_d | (done_d[i] & irq_en_d[i]);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == i) begin
        unique case (reg_sel)
          2'd0: rd_data = {29'd0, irq_en_q[i], dir_q[i], en_q[i]};
          2'd1: rd_data = 32'(remaining_q[i]);
          2'd2: rd_data = 32'(period_sh_q[i]);
          default: rd_data = {30'd0, done_q[i], state_q[i] != S_IDLE};
        endcase
      end
    end
    readdata_d = bus.avs_read ? rd_data : readdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]      <= S_IDLE;
        tmr_q[i]        <= '0;
        steps_sh_q[i]   <= '0;
        remaining_q[i]  <= '0;
        period_sh_q[i]  <= '0;
        period_act_q[i] <= '0;
      end
      en_q       <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      dir_act_q  <= '0;
      done_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      steps_sh_q   <= steps_sh_d;
      remaining_q  <= remaining_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      en_q         <= en_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      dir_act_q    <= dir_act_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

  // step decodes straight from the state flop, so reset drops it immediately.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      step[i] = (state_q[i] == S_HIGH);
      dir[i]  = (state_q[i] != S_IDLE) ? dir_act_q[i] : dir_q[i];
    end
  end

  assign enable_n         = ~en_q;
  assign irq              = irq_q;
  assign bus.avs_readdata = readdata_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
module tb_stepper_step_gen;
  localparam int N_CH = 2;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] step, dir, enable_n;
  logic            irq;
  logic [31:0]     rdv;
  int              total = 0;
  int              bad   = 0;

  stepper_step_gen_if #(.AW(AW)) bus ();

  stepper_step_gen #(
    .N_CH(N_CH), .CNT_W(24), .DIV_W(20), .SETUP_CYC(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .step     (step),
    .dir      (dir),
    .enable_n (enable_n),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  // Entered at the negedge just after the start write; walks the full move
  // (setup + 2*p*n cycles) and ends on the first idle cycle.
  task automatic chk_move(input string tag, input int ch, input int p, input int n);
    int len;
    logic exp;
    len = 2 + 2 * p * n;
    for (int k = 0; k <= len; k++) begin
      exp = (k >= 2) && (k < len) && (((k - 2) % (2 * p)) < p);
      chk(tag, 32'(step[ch]), 32'(exp));
      chk({tag, "_other"}, 32'(step[1-ch]), 32'd0);
      if (k < len) @(negedge clk);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_en_n", 32'(enable_n), 32'd3);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic move: P=3, 4 steps, irq enabled
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd4);
    wr(3'd0, 32'h07);
    chk("en_n_on", 32'(enable_n), 32'd2);
    chk("dir_idle", 32'(dir[0]), 32'd1);
    wr(3'd0, 32'h0F);
    chk_move("mv1", 0, 3, 4);
    chk("mv1_irq", 32'(irq), 32'd1);
    rd(3'd1, rdv); chk("mv1_steps", rdv, 32'd0);
    rd(3'd3, rdv); chk("mv1_status", rdv, 32'd2);
    rd(3'd0, rdv); chk("mv1_ctrl", rdv, 32'd7);
    rd(3'd2, rdv); chk("mv1_period", rdv, 32'd3);

    // Channel 1, PERIOD=0 treated as 1
    wr(3'd6, 32'd0);
    wr(3'd5, 32'd2);
    wr(3'd4, 32'h09);
    chk_move("ch1", 1, 1, 2);
    rd(3'd7, rdv); chk("ch1_status", rdv, 32'd2);

    // Abort with 5 steps left
    wr(3'd0, 32'h21);
    chk("clr_irq", 32'(irq), 32'd0);
    wr(3'd2, 32'd2);
    wr(3'd1, 32'd8);
    wr(3'd0, 32'h09);
    repeat (14) @(negedge clk);
    chk("ab_pre", 32'(step[0]), 32'd1);
    wr(3'd0, 32'h11);
    for (int k = 0; k < 4; k++) begin
      chk("ab_step", 32'(step[0]), 32'd0);
      @(negedge clk);
    end
    rd(3'd3, rdv); chk("ab_status", rdv, 32'd0);
    rd(3'd1, rdv); chk("ab_steps", rdv, 32'd5);

    // Shadow writes while busy
    wr(3'd1, 32'd2);
    wr(3'd0, 32'h09);
    wr(3'd2, 32'd10);
    chk("sh_setup", 32'(step[0]), 32'd0);
    wr(3'd0, 32'h03);
    for (int k = 2; k <= 10; k++) begin
      chk("sh_step", 32'(step[0]), 32'((k < 10) && (((k - 2) % 4) < 2)));
      chk("sh_dir", 32'(dir[0]), 32'(k >= 10));
      if (k < 10) @(negedge clk);
    end
    wr(3'd0, 32'h0B);
    chk("sh2_dir", 32'(dir[0]), 32'd1);
    chk_move("sh2", 0, 10, 2);
    rd(3'd3, rdv); chk("sh2_status", rdv, 32'd2);

    // Zero-step start
    wr(3'd1, 32'd0);
    wr(3'd0, 32'h25);
    chk("z_irq0", 32'(irq), 32'd0);
    wr(3'd0, 32'h0D);
    chk("z_irq1", 32'(irq), 32'd1);
    chk("z_step", 32'(step), 32'd0);
    rd(3'd3, rdv); chk("z_status", rdv, 32'd2);
    wr(3'd0, 32'h25);
    chk("z_irq_clr", 32'(irq), 32'd0);

    // Reset during HIGH
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd3);
    wr(3'd0, 32'h0F);
    repeat (3) @(negedge clk);
    chk("r_high", 32'(step[0]), 32'd1);
    #2 reset = 1'b1;
    #1 chk("r_async", 32'(step), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd(AW'(k), rdv);
      chk("r_reg", rdv, 32'd0);
      chk("r_step", 32'(step), 32'd0);
    end
    chk("r_en_n", 32'(enable_n), 32'd3);
    chk("r_dir", 32'(dir), 32'd0);
    chk("r_irq", 32'(irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
